ysyx_25060170_lsu: RTL and testbench



---
 rtl/ysyx_25060170_lsu.sv | 156 +++++++++++++++
 tb/tb_ysyx_25060170_lsu.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060170_lsu.sv
// Load/store unit: takes one execute-stage result at a time and hands it to writeback.
// Memory ops go through a single outstanding-request bus handshake.
//   clk, rst         : clock, asynchronous active-low reset
//   ex_valid/ls_ready: upstream handshake (exu_res, store_data, ls_op, rd_addr, rd_wen)
//   ls_valid/wb_ready: downstream handshake (ls_res, ls_rd_addr, ls_rd_wen, ls_err)
//   mem_*            : request/grant bus with rvalid as read data or write acknowledge
module ysyx_25060170_lsu #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ls_ready,
  input  logic [63:0]       exu_res,
  input  logic [63:0]       store_data,
  input  logic [4:0]        ls_op,
  input  logic [4:0]        rd_addr,
  input  logic              rd_wen,
  output logic              ls_valid,
  input  logic              wb_ready,
  output logic [63:0]       ls_res,
  output logic [4:0]        ls_rd_addr,
  output logic              ls_rd_wen,
  output logic              ls_err,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata
);

  localparam int unsigned XLEN = 64;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              accept_c;
  logic              mis_c;
  logic [7:0]        size_mask_c;
  logic [XLEN-1:0]   load_sh_c;
  logic [XLEN-1:0]   load_c;
  logic              ready_nxt;
  logic              valid_nxt;
  logic              req_nxt;
  logic [3:0]        op_q;
  logic [2:0]        off_q;
  logic              rd_wen_q;

  assign accept_c = ex_valid & ls_ready;

  // Alignment check on the incoming address for the requested size
  always_comb begin
    mis_c       = 1'b0;
    size_mask_c = 8'h01;
    case (ls_op[1:0])
      2'd0: begin mis_c = 1'b0;            size_mask_c = 8'h01; end
      2'd1: begin mis_c = exu_res[0];      size_mask_c = 8'h03; end
      2'd2: begin mis_c = |exu_res[1:0];   size_mask_c = 8'h0F; end
      default: begin mis_c = |exu_res[2:0]; size_mask_c = 8'hFF; end
    endcase
  end

  // Lane-align read data, then truncate and extend to the access size
  assign load_sh_c = mem_rdata >> {off_q, 3'b000};
  always_comb begin
    load_c = load_sh_c;
    case (op_q[1:0])
      2'd0: load_c = op_q[2] ? {56'd0, load_sh_c[7:0]}  : {{56{load_sh_c[7]}},  load_sh_c[7:0]};
      2'd1: load_c = op_q[2] ? {48'd0, load_sh_c[15:0]} : {{48{load_sh_c[15]}}, load_sh_c[15:0]};
      2'd2: load_c = op_q[2] ? {32'd0, load_sh_c[31:0]} : {{32{load_sh_c[31]}}, load_sh_c[31:0]};
      default: load_c = load_sh_c;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; misaligned and non-memory ops skip the bus entirely
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept_c) state_nxt = (!ls_op[4] || mis_c) ? S_DONE : S_REQ;
      S_REQ:  if (mem_gnt)    state_nxt = S_WAIT;
      S_WAIT: if (mem_rvalid) state_nxt = S_DONE;
      S_DONE: if (wb_ready)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state so they come straight off flops
  always_comb begin
    ready_nxt = 1'b0;
    valid_nxt = 1'b0;
    req_nxt   = 1'b0;
    case (state_nxt)
      S_IDLE:  ready_nxt = 1'b1;
      S_REQ:   req_nxt   = 1'b1;
      S_DONE:  valid_nxt = 1'b1;
      default: ready_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ls_ready <= 1'b1;
      ls_valid <= 1'b0;
      mem_req  <= 1'b0;
    end else begin
      ls_ready <= ready_nxt;
      ls_valid <= valid_nxt;
      mem_req  <= req_nxt;
    end
  end

  // Capture on accept; results only change on accept or on bus completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= '0;
      off_q      <= '0;
      rd_wen_q   <= 1'b0;
      ls_res     <= '0;
      ls_rd_addr <= '0;
      ls_rd_wen  <= 1'b0;
      ls_err     <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else if (accept_c) begin
      op_q       <= ls_op[3:0];
      off_q      <= exu_res[2:0];
      rd_wen_q   <= rd_wen;
      ls_rd_addr <= rd_addr;
      ls_err     <= ls_op[4] & mis_c;
      ls_rd_wen  <= rd_wen & ~ls_op[4];
      if (!ls_op[4] || mis_c) ls_res <= exu_res;
      if (ls_op[4] && !mis_c) begin
        mem_wen   <= ls_op[3];
        mem_addr  <= {exu_res[ADDR_W-1:3], 3'b000};
        mem_wdata <= ls_op[3] ? (store_data << {exu_res[2:0], 3'b000}) : '0;
        mem_wmask <= ls_op[3] ? 8'(size_mask_c << exu_res[2:0]) : 8'h00;
      end
    end else if (state == S_WAIT && mem_rvalid) begin
      ls_res    <= op_q[3] ? '0 : load_c;
      ls_rd_wen <= rd_wen_q & ~op_q[3];
    end
  end

endmodule

// File: tb/tb_ysyx_25060170_lsu.sv
// Directed bench: expected writeback results queued at issue, checked when ls_valid appears.
module tb_ysyx_25060170_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ls_ready;
  logic [63:0] exu_res;
  logic [63:0] store_data;
  logic [4:0]  ls_op;
  logic [4:0]  rd_addr;
  logic        rd_wen;
  logic        ls_valid;
  logic        wb_ready;
  logic [63:0] ls_res;
  logic [4:0]  ls_rd_addr;
  logic        ls_rd_wen;
  logic        ls_err;
  logic        mem_req;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        wen;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_25060170_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ls_ready(ls_ready),
    .exu_res(exu_res), .store_data(store_data), .ls_op(ls_op), .rd_addr(rd_addr),
    .rd_wen(rd_wen), .ls_valid(ls_valid), .wb_ready(wb_ready), .ls_res(ls_res),
    .ls_rd_addr(ls_rd_addr), .ls_rd_wen(ls_rd_wen), .ls_err(ls_err),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one op for a single accept edge, then scramble inputs to prove capture
  task automatic issue(input logic [63:0] res, input logic [63:0] sd, input logic [4:0] op,
                       input logic [4:0] rd, input logic wen, input bit push, input exp_t e);
    chk("ready_before_issue", 64'(ls_ready), 64'd1);
    ex_valid = 1'b1; exu_res = res; store_data = sd; ls_op = op; rd_addr = rd; rd_wen = wen;
    if (push) sb.push_back(e);
    @(posedge clk); @(negedge clk);
    ex_valid   = 1'b0;
    exu_res    = {$urandom, $urandom};
    store_data = {$urandom, $urandom};
    ls_op      = 5'($urandom);
    rd_addr    = 5'($urandom);
    rd_wen     = 1'($urandom);
  endtask

  // Play the memory: grant after gnt_dly REQ cycles, rvalid after rv_dly WAIT cycles
  task automatic serve(input int gnt_dly, input int rv_dly, input logic [63:0] rdata,
                       input logic [31:0] a, input logic w, input logic [7:0] m,
                       input logic [63:0] wd);
    for (int i = 0; i <= gnt_dly; i++) begin
      chk("mem_req_held", 64'(mem_req), 64'd1);
      chk("mem_addr", 64'(mem_addr), 64'(a));
      chk("mem_wen", 64'(mem_wen), 64'(w));
      chk("mem_wmask", 64'(mem_wmask), 64'(m));
      if (w) chk("mem_wdata", mem_wdata, wd);
      if (i == gnt_dly) mem_gnt = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    mem_gnt = 1'b0;
    chk("mem_req_drop", 64'(mem_req), 64'd0);
    for (int i = 0; i < rv_dly; i++) begin
      chk("wait_no_valid", 64'(ls_valid), 64'd0);
      @(posedge clk); @(negedge clk);
    end
    mem_rvalid = 1'b1; mem_rdata = rdata;
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
  endtask

  // Result must be present now; optionally stall writeback and probe hold-off
  task automatic retire(input int hold);
    exp_t e;
    logic [63:0] r0;
    chk("ls_valid", 64'(ls_valid), 64'd1);
    chk("ls_ready_busy", 64'(ls_ready), 64'd0);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 64'd0, 64'(ls_valid));
      e = '{res: 64'd0, rd: 5'd0, wen: 1'b0, err: 1'b0};
    end else e = sb.pop_front();
    chk("ls_res", ls_res, e.res);
    chk("ls_rd_addr", 64'(ls_rd_addr), 64'(e.rd));
    chk("ls_rd_wen", 64'(ls_rd_wen), 64'(e.wen));
    chk("ls_err", 64'(ls_err), 64'(e.err));
    r0 = ls_res;
    if (hold > 0) begin
      wb_ready = 1'b0;
      ex_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); @(negedge clk);
        chk("bp_valid", 64'(ls_valid), 64'd1);
        chk("bp_res", ls_res, r0);
        chk("bp_ready", 64'(ls_ready), 64'd0);
      end
      ex_valid = 1'b0;
      wb_ready = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    chk("valid_one_cycle", 64'(ls_valid), 64'd0);
    chk("ready_after", 64'(ls_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b0; ex_valid = 1'b0; exu_res = '0; store_data = '0; ls_op = '0;
    rd_addr = '0; rd_wen = 1'b0; wb_ready = 1'b1; mem_gnt = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ls_valid", 64'(ls_valid), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_ls_err", 64'(ls_err), 64'd0);
    chk("rst_ls_res", ls_res, 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_rd_wen", 64'(ls_rd_wen), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(ls_ready), 64'd1);

    // Non-memory op: result one edge after accept
    issue(64'h1234, 64'h0, 5'b00000, 5'd5, 1'b1, 1'b1, '{res: 64'h1234, rd: 5'd5, wen: 1'b1, err: 1'b0});
    chk("alu_no_req", 64'(mem_req), 64'd0);
    retire(0);

    // LB at offset 3, immediate grant and rvalid
    issue(64'h80000003, 64'h0, 5'b10000, 5'd7, 1'b1, 1'b1, '{res: 64'hFFFFFFFF_FFFFFFF0, rd: 5'd7, wen: 1'b1, err: 1'b0});
    serve(0, 0, 64'h00000000_F0000000, 32'h80000000, 1'b0, 8'h00, 64'h0);
    retire(0);

    // LHU and LH at offset 6
    issue(64'h80000006, 64'h0, 5'b10101, 5'd8, 1'b1, 1'b1, '{res: 64'h00000000_0000ABCD, rd: 5'd8, wen: 1'b1, err: 1'b0});
    serve(1, 0, 64'hABCD0000_00000000, 32'h80000000, 1'b0, 8'h00, 64'h0);
    retire(0);
    issue(64'h80000006, 64'h0, 5'b10001, 5'd8, 1'b1, 1'b1, '{res: 64'hFFFFFFFF_FFFFABCD, rd: 5'd8, wen: 1'b1, err: 1'b0});
    serve(0, 1, 64'hABCD0000_00000000, 32'h80000000, 1'b0, 8'h00, 64'h0);
    retire(0);

    // SW at offset 4 with grant held off three cycles
    issue(64'h80000004, 64'hDEADBEEF, 5'b11010, 5'd3, 1'b1, 1'b1, '{res: 64'h0, rd: 5'd3, wen: 1'b0, err: 1'b0});
    serve(3, 1, 64'h0, 32'h80000000, 1'b1, 8'hF0, 64'hDEADBEEF_00000000);
    retire(0);

    // SB at offset 5
    issue(64'h10000005, 64'h11223344_556677AB, 5'b11000, 5'd4, 1'b1, 1'b1, '{res: 64'h0, rd: 5'd4, wen: 1'b0, err: 1'b0});
    serve(0, 2, 64'h0, 32'h10000000, 1'b1, 8'h20, 64'h6677AB00_00000000);
    retire(0);

    // LD aligned, LW signed at offset 4
    issue(64'h80000008, 64'h0, 5'b10011, 5'd10, 1'b1, 1'b1, '{res: 64'h01234567_89ABCDEF, rd: 5'd10, wen: 1'b1, err: 1'b0});
    serve(0, 0, 64'h01234567_89ABCDEF, 32'h80000008, 1'b0, 8'h00, 64'h0);
    retire(0);
    issue(64'h8000000C, 64'h0, 5'b10010, 5'd11, 1'b1, 1'b1, '{res: 64'hFFFFFFFF_80000001, rd: 5'd11, wen: 1'b1, err: 1'b0});
    serve(0, 0, 64'h80000001_00000000, 32'h80000008, 1'b0, 8'h00, 64'h0);
    retire(0);

    // Misaligned LW with writeback backpressure, misaligned SD
    issue(64'h80000002, 64'h0, 5'b10010, 5'd9, 1'b1, 1'b1, '{res: 64'h80000002, rd: 5'd9, wen: 1'b0, err: 1'b1});
    chk("mis_no_req", 64'(mem_req), 64'd0);
    retire(5);
    issue(64'h80000004, 64'h55, 5'b11011, 5'd12, 1'b1, 1'b1, '{res: 64'h80000004, rd: 5'd12, wen: 1'b0, err: 1'b1});
    chk("mis_sd_no_req", 64'(mem_req), 64'd0);
    retire(0);

    // Reset pulse while waiting for read data; later stray rvalid must be ignored
    issue(64'h80000000, 64'h0, 5'b10011, 5'd1, 1'b1, 1'b0, '{res: 64'h0, rd: 5'd0, wen: 1'b0, err: 1'b0});
    chk("pre_rst_req", 64'(mem_req), 64'd1);
    mem_gnt = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_mid_req", 64'(mem_req), 64'd0);
    chk("rst_mid_valid", 64'(ls_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_rvalid_no_valid", 64'(ls_valid), 64'd0);
      chk("stray_rvalid_ready", 64'(ls_ready), 64'd1);
      @(posedge clk); @(negedge clk);
    end

    // Unit still works after the reset
    issue(64'hCAFE, 64'h0, 5'b00000, 5'd2, 1'b1, 1'b1, '{res: 64'hCAFE, rd: 5'd2, wen: 1'b1, err: 1'b0});
    retire(0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
